sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, giving the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, giving the address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have, for i in {0,1}: req_i (in, 1), we_i (in, 1, 1 = write), addr_i (in, ADDR_WIDTH), wdata_i (in, DATA_WIDTH); these are requester i's command inputs.
REQ-006 SHALL have, for i in {0,1}: gnt_i (out, 1, command accepted), rvalid_i (out, 1, read data valid), rdata_i (out, DATA_WIDTH).
REQ-007 SHALL have memory-side ports:
- mem_addr (out, ADDR_WIDTH).
- mem_wr_n (out, 1): 0 = write at the next edge; 1 = read, with data registered at the next edge.
- mem_wdata (out, DATA_WIDTH).
- mem_rdata (in, DATA_WIDTH): valid in the cycle after a read command.

Function
REQ-008 SHALL implement FSM states IDLE, CMD, RESP; reset state IDLE.
REQ-009 In IDLE with no req_i high: stay IDLE; mem_wr_n=1; mem_addr and mem_wdata hold their last values.
REQ-010 In IDLE with one or more req_i high:
- choose a winner w (REQ-013);
- register mem_addr=addr_w, mem_wdata=wdata_w, mem_wr_n=~we_w;
- latch w and we_w;
- go to CMD.
REQ-011 In CMD:
- gnt_w=1 for exactly this one cycle; the other gnt is 0;
- the memory performs the operation at the closing edge;
- next state is RESP if the command was a read, IDLE if it was a write;
- mem_wr_n returns to 1 at the closing edge.
REQ-012 In RESP: rvalid_w=1 and rdata_w=mem_rdata for exactly this one cycle; next state is IDLE.
REQ-013 Winner selection uses round-robin pointer prio (reset 0):
- if both requesters are high, grant requester prio;
- if only one is high, grant it;
- after any grant, prio = the non-winner.
REQ-014 Requests are sampled only in IDLE. req_i values during CMD or RESP are ignored.
REQ-015 A requester SHALL hold its command stable from the cycle it asserts req_i until it sees gnt_i. The command is committed once sampled; withdrawal after sampling does not cancel it.
REQ-016 req_i still high in the IDLE cycle after gnt_i is a new request.
REQ-017 Throughput: one write per 2 cycles; one read per 3 cycles. Latency from req sampled to rvalid is 2 cycles.
REQ-018 rdata_i holds its value outside rvalid_i; its reset value is 0.
REQ-019 With both requesters continuously requesting, grants SHALL strictly alternate (no starvation).

Reset
REQ-020 rst high SHALL immediately, without waiting for a clock edge:
- force state IDLE and prio=0;
- force gnt_i=0, rvalid_i=0, rdata_i=0;
- force mem_wr_n=1, mem_addr=0, mem_wdata=0.
REQ-021 Reset during CMD SHALL abort the command: no memory write, no gnt. Reset during RESP SHALL suppress rvalid.
REQ-022 After rst deasserts, the first edge evaluates IDLE normally.

Structure
REQ-023 SHALL place the FSM state encoding (IDLE, CMD, RESP) and the requester-index constants in a shared package, sram_ctrl_pkg.
REQ-024 SHALL factor the round-robin pointer and winner selection into sub-module rr_arb2. The FSM and memory-side registers stay in sram_arbiter.

Verification
REQ-025 After reset, requester 0 writes addr=1 data=2; later it reads addr=1. Required: gnt_0 for one cycle in each CMD; rvalid_0=1 with rdata_0=2 two cycles after the read request was sampled.
REQ-026 Both requesters issue a read in the same IDLE cycle after reset. Required: requester 0 is granted first and requester 1 next; rvalid_1 data matches the memory contents at its address.
REQ-027 Both requesters request continuously for 8 grants. Required: gnts alternate 0,1,0,1,...; no gnt is ever simultaneous.
REQ-028 Assert rst in the CMD cycle of a write of data=3 to addr=2, then read addr=2. Required: the old value is returned; gnt_i and rvalid_i stay 0 during reset; mem_wr_n=1 during reset.
REQ-029 Requester 1 holds req_1 high through gnt_1 and into the following cycle. Required: the held request is treated as a second command and yields a second gnt_1.
REQ-030 Idle for 10 cycles with no requests. Required: mem_wr_n=1 throughout; no gnt and no rvalid.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: FSM state encoding
// and requester index constants.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection; the pointer moves to the loser on
// every accepted grant so continuous contention strictly alternates.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner
);

  logic prio;

  always_comb begin
    if (req == 2'b11) winner = prio;
    else              winner = req[1] ? REQ1 : REQ0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= REQ0;
    else if (advance) prio <= ~winner;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto a single-port synchronous SRAM.
// state | meaning
// IDLE  | sample requests, register winner's command onto the memory bus
// CMD   | memory executes the command; grant the winner
// RESP  | read data returned to the winner (reads only)
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_n,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t state, state_nx;
  logic   winner, win_q, we_q, we_sel, start;
  logic [DATA_WIDTH-1:0] rdata_q0, rdata_q1;

  assign start  = (state == ST_IDLE) && (req_0 || req_1);
  assign we_sel = (winner == REQ1) ? we_1 : we_0;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_1, req_0}),
    .advance (start),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CMD;
      ST_CMD:  state_nx = we_q ? ST_IDLE : ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read data is passed straight through in RESP and held afterwards.
  always_comb begin
    gnt_0    = (state == ST_CMD)  && (win_q == REQ0);
    gnt_1    = (state == ST_CMD)  && (win_q == REQ1);
    rvalid_0 = (state == ST_RESP) && (win_q == REQ0);
    rvalid_1 = (state == ST_RESP) && (win_q == REQ1);
    rdata_0  = rvalid_0 ? mem_rdata : rdata_q0;
    rdata_1  = rvalid_1 ? mem_rdata : rdata_q1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_n  <= 1'b1;
      win_q     <= REQ0;
      we_q      <= 1'b0;
      rdata_q0  <= '0;
      rdata_q1  <= '0;
    end else begin
      mem_wr_n <= 1'b1;
      if (start) begin
        mem_addr  <= (winner == REQ1) ? addr_1  : addr_0;
        mem_wdata <= (winner == REQ1) ? wdata_1 : wdata_0;
        mem_wr_n  <= ~we_sel;
        win_q     <= winner;
        we_q      <= we_sel;
      end
      if (rvalid_0) rdata_q0 <= mem_rdata;
      if (rvalid_1) rdata_q1 <= mem_rdata;
    end
  end

endmodule
